// File: rtl/ring_pkg.sv
// ring_pkg: packet field positions and packet struct shared by the ring routers and link endpoints.
package ring_pkg;
    localparam int VALID_BIT = 48;
    localparam int TS_MSB    = 47;
    localparam int TS_LSB    = 32;
    localparam int SRC_MSB   = 31;
    localparam int SRC_LSB   = 16;
    localparam int DST_MSB   = 15;
    localparam int DST_LSB   = 0;

    typedef struct packed {
        logic        valid;
        logic [15:0] timestamp;
        logic [15:0] source;
        logic [15:0] destination;
    } ring_packet_t;
endpackage

// File: rtl/ring_rx_fifo.sv
// ring_rx_fifo: circular packet buffer of any depth with push, pop, full, empty and count.
module ring_rx_fifo #(
    parameter int DATA_W = 49,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [DATA_W-1:0]          i_data,
    input  logic                       i_pop,
    output logic [DATA_W-1:0]          o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wr;
    logic [PW-1:0]     r_rd;
    logic [CW-1:0]     r_cnt;
    logic              w_wr;
    logic              w_rd;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    // A pop frees the head slot first, so a full buffer still accepts a simultaneous push.
    assign w_wr    = i_push & (~o_full | i_pop);
    assign w_rd    = i_pop & ~o_empty;
    assign o_full  = r_cnt == CW'(DEPTH);
    assign o_empty = r_cnt == '0;
    assign o_count = r_cnt;
    assign o_data  = r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr) r_wr <= wrap_inc(r_wr);
            if (w_rd) r_rd <= wrap_inc(r_rd);
            r_cnt <= r_cnt + CW'(w_wr) - CW'(w_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr] <= i_data;
    end
endmodule

// File: rtl/ring_link_rx.sv
// ring_link_rx: ring link receive endpoint with FIFO, on/off backpressure and sticky overflow flag.
// Defining RING_RX_STATS_EN adds popped-packet and accumulated-latency counters.
module ring_link_rx
    import ring_pkg::*;
#(
    parameter int PACKET_SIZE    = 49,
    parameter int BUFFER_SIZE    = 4,
    parameter int STOP_THRESHOLD = BUFFER_SIZE - 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [15:0]                      clk_counter,
    input  logic [PACKET_SIZE-1:0]           link_in,
    output logic                             backpressure_wr,
    output logic                             out_valid,
    output logic [PACKET_SIZE-1:0]           out_packet,
    input  logic                             out_ready,
    output logic                             overflow_err,
    output logic [$clog2(BUFFER_SIZE+1)-1:0] occupancy
`ifdef RING_RX_STATS_EN
    ,
    output logic [63:0]                      total_packet_recieve,
    output logic [63:0]                      total_latency
`endif
);
    localparam int CW = $clog2(BUFFER_SIZE+1);

    logic                   r_bp;
    logic                   r_ovf;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_acc;
    logic                   w_full;
    logic                   w_empty;
    logic [CW-1:0]          w_occ_next;
    logic [PACKET_SIZE-1:0] w_fifo_data;
    ring_packet_t           w_out;

    ring_rx_fifo #(.DATA_W(PACKET_SIZE), .DEPTH(BUFFER_SIZE)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (link_in),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (occupancy)
    );

    assign w_push     = link_in[VALID_BIT];
    assign w_pop      = out_valid & out_ready;
    assign w_acc      = w_push & (~w_full | w_pop);
    assign w_occ_next = occupancy + CW'(w_acc) - CW'(w_pop);
    assign out_valid  = ~w_empty;

    always_comb begin
        w_out       = w_fifo_data;
        w_out.valid = 1'b1;
    end

    assign out_packet      = out_valid ? PACKET_SIZE'(w_out) : '0;
    assign backpressure_wr = r_bp;
    assign overflow_err    = r_ovf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bp  <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            r_bp  <= w_occ_next >= CW'(STOP_THRESHOLD);
            r_ovf <= r_ovf | (w_push & ~w_acc);
        end
    end

`ifdef RING_RX_STATS_EN
    logic [63:0] r_tot;
    logic [63:0] r_lat;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tot <= '0;
            r_lat <= '0;
        end else if (w_pop) begin
            r_tot <= r_tot + 64'd1;
            r_lat <= r_lat + 64'(16'(clk_counter - w_out.timestamp));
        end
    end

    assign total_packet_recieve = r_tot;
    assign total_latency        = r_lat;
`else
    logic w_unused;
    assign w_unused = ^clk_counter;
`endif
endmodule

// File: tb/tb_ring_link_rx.sv
// tb_ring_link_rx: scoreboard bench with directed scenarios followed by random push/pop traffic.
module tb_ring_link_rx;
    localparam int BS   = 4;
    localparam int STOP = BS - 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] clk_counter;
    logic [48:0] link_in;
    logic        backpressure_wr;
    logic        out_valid;
    logic [48:0] out_packet;
    logic        out_ready;
    logic        overflow_err;
    logic [2:0]  occupancy;
`ifdef RING_RX_STATS_EN
    logic [63:0] total_packet_recieve;
    logic [63:0] total_latency;
`endif

    ring_link_rx dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .clk_counter     (clk_counter),
        .link_in         (link_in),
        .backpressure_wr (backpressure_wr),
        .out_valid       (out_valid),
        .out_packet      (out_packet),
        .out_ready       (out_ready),
        .overflow_err    (overflow_err),
        .occupancy       (occupancy)
`ifdef RING_RX_STATS_EN
        ,
        .total_packet_recieve (total_packet_recieve),
        .total_latency        (total_latency)
`endif
    );

    always #5 clk = ~clk;

    logic [48:0] q[$];
    int          mcount;
    logic        exp_ovf;
    logic [63:0] exp_tot;
    logic [63:0] exp_lat;
    int          n_cmp;
    int          n_bad;

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [47:0] pk(input logic [15:0] ts, input logic [15:0] src, input logic [15:0] dst);
        return {ts, src, dst};
    endfunction

    task automatic check();
        cmp("occupancy", 64'(occupancy), 64'(mcount));
        cmp("backpressure", 64'(backpressure_wr), 64'(mcount >= STOP));
        cmp("overflow", 64'(overflow_err), 64'(exp_ovf));
        cmp("out_valid", 64'(out_valid), 64'(mcount != 0));
        if (mcount != 0 && q.size() != 0) cmp("head", 64'(out_packet), 64'(q[0]));
        else cmp("idle_packet", 64'(out_packet), 64'd0);
`ifdef RING_RX_STATS_EN
        cmp("stat_count", total_packet_recieve, exp_tot);
        cmp("stat_latency", total_latency, exp_lat);
`endif
    endtask

    task automatic cyc(input logic v, input logic [47:0] pl, input logic rdy);
        logic pop_m;
        logic ok;
        @(negedge clk);
        check();
        #1;
        rst_n       = 1'b1;
        link_in     = {v, pl};
        out_ready   = rdy;
        clk_counter = clk_counter + 16'd1;
        pop_m = rdy && mcount > 0;
        ok    = v && (mcount < BS || pop_m);
        if (v && !ok) exp_ovf = 1'b1;
        if (ok) q.push_back({1'b1, pl});
        mcount = mcount + int'(ok) - int'(pop_m);
    endtask

    task automatic do_reset();
        @(negedge clk);
        check();
        #1;
        rst_n     = 1'b0;
        link_in   = '0;
        out_ready = 1'b0;
        q.delete();
        mcount  = 0;
        exp_ovf = 1'b0;
        exp_tot = '0;
        exp_lat = '0;
    endtask

    // Monitor: consumes the expected head whenever the DUT offers a packet that is accepted.
    initial begin
        logic [48:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    cmp("pop_unexpected", 64'(out_packet), 64'd0);
                end else begin
                    e = q.pop_front();
                    cmp("pop_packet", 64'(out_packet), 64'(e));
                    exp_tot = exp_tot + 64'd1;
                    exp_lat = exp_lat + 64'(clk_counter - e[47:32]);
                end
            end
        end
    end

    initial begin
        logic [47:0] pl;
        rst_n = 1'b0; link_in = '0; out_ready = 1'b0; clk_counter = '0;
        mcount = 0; exp_ovf = 1'b0; exp_tot = '0; exp_lat = '0;
        n_cmp = 0; n_bad = 0;
        repeat (10) cyc(1'b0, 48'd0, 1'b0);
        cyc(1'b1, pk(16'd5, 16'd1, 16'd3), 1'b0);
        cyc(1'b1, pk(16'd6, 16'd1, 16'd3), 1'b0);
        cyc(1'b0, 48'd0, 1'b0);
        repeat (3) cyc(1'b0, 48'd0, 1'b1);
        for (int i = 0; i < BS; i++) cyc(1'b1, pk(16'(10 + i), 16'd2, 16'd7), 1'b0);
        cyc(1'b1, pk(16'd20, 16'd2, 16'd7), 1'b1);
        cyc(1'b0, 48'd0, 1'b0);
        cyc(1'b1, pk(16'd99, 16'd9, 16'd9), 1'b0);
        cyc(1'b0, 48'd0, 1'b0);
        repeat (6) cyc(1'b0, 48'd0, 1'b1);
        do_reset();
        cyc(1'b1, pk(16'hFFF0, 16'd4, 16'd5), 1'b0);
        clk_counter = 16'h000F;
        cyc(1'b0, 48'd0, 1'b1);
        cyc(1'b0, 48'd0, 1'b0);
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, pk(16'(40 + i), 16'd6, 16'd1), 1'b0);
        cyc(1'b0, 48'd0, 1'b0);
        do_reset();
        cyc(1'b0, 48'd0, 1'b0);
        for (int i = 0; i < 800; i++) begin
            pl = {16'($urandom), 16'($urandom), 16'($urandom)};
            if ($urandom_range(0, 99) == 0) do_reset();
            else cyc(1'($urandom), pl, $urandom_range(0, 2) != 0);
        end
        repeat (BS + 2) cyc(1'b0, 48'd0, 1'b1);
        cyc(1'b0, 48'd0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
